udp_tx_frame_buf: RTL and testbench

Store-and-forward stage between the register controller's TX payload stream and the UDP TX path of the Ethernet stack. Buffers one complete response frame and counts its bytes. Once the frame's last byte arrives, emits a UDP header with destination IP/port, source port and UDP length, then replays the payload. Frames longer than the buffer are dropped whole.

---
 rtl/udp_tx_frame_buf.sv | 124 ++++++++++++
 tb/tb_udp_tx_frame_buf.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_frame_buf.sv
// Store-and-forward buffer for one UDP TX frame: fills a byte RAM, emits the UDP
// header once tlast arrives, then replays the payload. Oversized frames are dropped.
module udp_tx_frame_buf #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] SRC_PORT = 16'd1234
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_tx_udp_payload_axis_tdata,
    input  logic        i_tx_udp_payload_axis_tvalid,
    input  logic        i_tx_udp_payload_axis_tlast,
    output logic        o_tx_udp_payload_axis_tready,
    input  logic [31:0] i_ip_adr,
    input  logic [15:0] i_port_nbr,
    output logic        o_m_udp_hdr_valid,
    input  logic        i_m_udp_hdr_ready,
    output logic [31:0] o_m_ip_dest_ip,
    output logic [15:0] o_m_udp_dest_port,
    output logic [15:0] o_m_udp_source_port,
    output logic [15:0] o_m_udp_length,
    output logic [7:0]  o_m_udp_payload_axis_tdata,
    output logic        o_m_udp_payload_axis_tvalid,
    output logic        o_m_udp_payload_axis_tlast,
    input  logic        i_m_udp_payload_axis_tready,
    output logic        o_overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {FILL, HDR, SEND, DROP} state_t;

    // state is left as a plainly named signal so checkers can bind to it
    state_t      state;
    logic [7:0]  ram [DEPTH];
    logic [AW:0] wr_cnt;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_cnt_next;
    logic        in_beat;
    logic        out_beat;

    // Both streams are AXIS: a beat transfers on a rising edge where valid and ready are both high.
    assign in_beat     = i_tx_udp_payload_axis_tvalid && o_tx_udp_payload_axis_tready;
    assign out_beat    = o_m_udp_payload_axis_tvalid && i_m_udp_payload_axis_tready;
    assign wr_cnt_next = wr_cnt + 1'b1;

    assign o_m_udp_source_port = SRC_PORT;

    // wr_cnt never exceeds DEPTH-1 while a byte is written in FILL
    always_ff @(posedge i_clk) begin
        if (in_beat && state == FILL)
            ram[wr_cnt[AW-1:0]] <= i_tx_udp_payload_axis_tdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                        <= FILL;
            wr_cnt                       <= '0;
            rd_ptr                       <= '0;
            o_tx_udp_payload_axis_tready <= 1'b0;
            o_m_udp_hdr_valid            <= 1'b0;
            o_m_ip_dest_ip               <= '0;
            o_m_udp_dest_port            <= '0;
            o_m_udp_length               <= '0;
            o_m_udp_payload_axis_tdata   <= '0;
            o_m_udp_payload_axis_tvalid  <= 1'b0;
            o_m_udp_payload_axis_tlast   <= 1'b0;
            o_overflow                   <= 1'b0;
        end else begin
            o_overflow <= 1'b0;
            case (state)
                FILL: begin
                    o_tx_udp_payload_axis_tready <= 1'b1;
                    if (in_beat) begin
                        wr_cnt <= wr_cnt_next;
                        if (i_tx_udp_payload_axis_tlast) begin
                            state                        <= HDR;
                            o_tx_udp_payload_axis_tready <= 1'b0;
                            o_m_udp_hdr_valid            <= 1'b1;
                            o_m_ip_dest_ip               <= i_ip_adr;
                            o_m_udp_dest_port            <= i_port_nbr;
                            o_m_udp_length               <= 16'd8 + 16'(wr_cnt_next);
                        end else if (wr_cnt == (AW+1)'(DEPTH - 1)) begin
                            state <= DROP;
                        end
                    end
                end
                HDR: begin
                    // first byte is fetched here so tvalid can rise right after the handshake
                    if (i_m_udp_hdr_ready) begin
                        state                       <= SEND;
                        o_m_udp_hdr_valid           <= 1'b0;
                        o_m_udp_payload_axis_tdata  <= ram[0];
                        o_m_udp_payload_axis_tvalid <= 1'b1;
                        o_m_udp_payload_axis_tlast  <= (wr_cnt == (AW+1)'(1));
                        rd_ptr                      <= (AW+1)'(1);
                    end
                end
                SEND: begin
                    if (out_beat) begin
                        if (o_m_udp_payload_axis_tlast) begin
                            state                        <= FILL;
                            wr_cnt                       <= '0;
                            o_m_udp_payload_axis_tvalid  <= 1'b0;
                            o_m_udp_payload_axis_tlast   <= 1'b0;
                            o_tx_udp_payload_axis_tready <= 1'b1;
                        end else begin
                            o_m_udp_payload_axis_tdata <= ram[rd_ptr[AW-1:0]];
                            o_m_udp_payload_axis_tlast <= (rd_ptr == wr_cnt - 1'b1);
                            rd_ptr                     <= rd_ptr + 1'b1;
                        end
                    end
                end
                DROP: begin
                    o_tx_udp_payload_axis_tready <= 1'b1;
                    if (in_beat && i_tx_udp_payload_axis_tlast) begin
                        state      <= FILL;
                        wr_cnt     <= '0;
                        o_overflow <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_frame_buf.sv
// Bench for udp_tx_frame_buf (DEPTH=16): table-driven frames, hand-written reset
// sequence and random frames checked against a frame-level reference model.
module tb_udp_tx_frame_buf;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] ip_adr;
    logic [15:0] port_nbr;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] dest_ip;
    logic [15:0] dest_port;
    logic [15:0] src_port;
    logic [15:0] udp_len;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int          len;
        logic [7:0]  data [20];
        logic [31:0] ip;
        logic [15:0] port;
        int          hdr_delay;
        int          mode;
        logic [15:0] exp_len;
        bit          exp_drop;
    } vec_t;

    vec_t tbl [6];

    udp_tx_frame_buf #(.DEPTH(DEPTH), .SRC_PORT(16'd1234)) dut (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_tx_udp_payload_axis_tdata  (in_data),
        .i_tx_udp_payload_axis_tvalid (in_valid),
        .i_tx_udp_payload_axis_tlast  (in_last),
        .o_tx_udp_payload_axis_tready (in_ready),
        .i_ip_adr                     (ip_adr),
        .i_port_nbr                   (port_nbr),
        .o_m_udp_hdr_valid            (hdr_valid),
        .i_m_udp_hdr_ready            (hdr_ready),
        .o_m_ip_dest_ip               (dest_ip),
        .o_m_udp_dest_port            (dest_port),
        .o_m_udp_source_port          (src_port),
        .o_m_udp_length               (udp_len),
        .o_m_udp_payload_axis_tdata   (out_data),
        .o_m_udp_payload_axis_tvalid  (out_valid),
        .o_m_udp_payload_axis_tlast   (out_last),
        .i_m_udp_payload_axis_tready  (out_ready),
        .o_overflow                   (overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame fits if it is at most DEPTH bytes; a fitting frame yields a header
    // of length 8+N and the same N bytes back in order.
    function automatic bit model_drop(input int len);
        return len > DEPTH;
    endfunction

    function automatic logic [15:0] model_len(input int len);
        return 16'(8 + len);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_frame();
        int i = 0;
        int guard = 0;
        while (i < frame_q.size()) begin
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            if (in_ready) i++;
            step();
            guard++;
            if (guard > 500) begin
                check("send_timeout", 32'(i), 32'(frame_q.size()));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic collect(input int mode);
        int guard = 0;
        int ph = 0;
        bit stalled = 0;
        bit done = 0;
        logic [7:0] pd = '0;
        logic pl = 0;
        logic [7:0] e;
        while (!done) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            check("out_tvalid", 32'(out_valid), 32'd1);
            if (!out_valid) break;
            check("in_backpressure", 32'(in_ready), 32'd0);
            if (stalled) begin
                check("hold_tdata", 32'(out_data), 32'(pd));
                check("hold_tlast", 32'(out_last), 32'(pl));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(out_data), 32'hffff_ffff);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    check("out_tdata", 32'(out_data), 32'(e));
                    check("out_tlast", 32'(out_last), 32'(exp_q.size() == 0));
                    done = (exp_q.size() == 0) || out_last;
                end
                stalled = 0;
            end else begin
                stalled = 1;
                pd = out_data;
                pl = out_last;
            end
            step();
            guard++;
            if (guard > 300) begin
                check("collect_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        out_ready = 1'b0;
        check("out_idle", 32'(out_valid), 32'd0);
        check("recovery_tready", 32'(in_ready), 32'd1);
    endtask

    // Sends frame_q and checks header or drop behaviour, then the replayed payload.
    task automatic run_frame(input logic [31:0] ip, input logic [15:0] port, input int delay,
                             input int mode, input logic [15:0] exp_len, input bit exp_drop);
        int guard;
        ip_adr   = ip;
        port_nbr = port;
        exp_q.delete();
        if (!exp_drop) foreach (frame_q[k]) exp_q.push_back(frame_q[k]);
        send_frame();
        check("overflow_pulse", 32'(overflow), 32'(exp_drop));
        check("hdr_latency", 32'(hdr_valid), 32'(!exp_drop));
        if (exp_drop) begin
            step();
            check("overflow_once", 32'(overflow), 32'd0);
            check("no_hdr_on_drop", 32'(hdr_valid), 32'd0);
            check("drop_recovery", 32'(in_ready), 32'd1);
            return;
        end
        guard = 0;
        while (!hdr_valid && guard < 20) begin
            step();
            guard++;
        end
        for (int d = 0; d < delay; d++) begin
            hdr_ready = 1'b0;
            ip_adr    = $urandom;
            port_nbr  = 16'($urandom);
            check("hdr_hold_valid", 32'(hdr_valid), 32'd1);
            check("hdr_hold_ip", dest_ip, ip);
            check("hdr_hold_port", 32'(dest_port), 32'(port));
            check("hdr_in_tready", 32'(in_ready), 32'd0);
            step();
        end
        check("hdr_len", 32'(udp_len), 32'(exp_len));
        check("hdr_ip", dest_ip, ip);
        check("hdr_port", 32'(dest_port), 32'(port));
        check("hdr_src", 32'(src_port), 32'd1234);
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        check("hdr_done", 32'(hdr_valid), 32'd0);
        collect(mode);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len;
        rst = 1'b1; in_data = '0; in_valid = 0; in_last = 0;
        ip_adr = '0; port_nbr = '0; hdr_ready = 0; out_ready = 0;

        tbl[0].len = 4; tbl[0].ip = 32'hC0A80180; tbl[0].port = 16'd1234;
        tbl[0].hdr_delay = 0; tbl[0].mode = 0; tbl[0].exp_len = 16'd12; tbl[0].exp_drop = 0;
        tbl[0].data[0] = 8'hAB; tbl[0].data[1] = 8'hCD; tbl[0].data[2] = 8'h12; tbl[0].data[3] = 8'h34;

        tbl[1].len = 7; tbl[1].ip = 32'h0A000001; tbl[1].port = 16'd5000;
        tbl[1].hdr_delay = 10; tbl[1].mode = 0; tbl[1].exp_len = 16'd15; tbl[1].exp_drop = 0;
        tbl[1].data[0] = 8'h3E; tbl[1].data[1] = 8'hFE; tbl[1].data[2] = 8'hDC; tbl[1].data[3] = 8'hBA;
        tbl[1].data[4] = 8'h98; tbl[1].data[5] = 8'h76; tbl[1].data[6] = 8'h54;

        tbl[2].len = 4; tbl[2].ip = 32'h01020304; tbl[2].port = 16'd80;
        tbl[2].hdr_delay = 1; tbl[2].mode = 1; tbl[2].exp_len = 16'd12; tbl[2].exp_drop = 0;
        tbl[2].data[0] = 8'h11; tbl[2].data[1] = 8'h22; tbl[2].data[2] = 8'h33; tbl[2].data[3] = 8'h44;

        tbl[3].len = 20; tbl[3].ip = 32'hDEADBEEF; tbl[3].port = 16'd9;
        tbl[3].hdr_delay = 0; tbl[3].mode = 0; tbl[3].exp_len = 16'd0; tbl[3].exp_drop = 1;
        for (int i = 0; i < 20; i++) tbl[3].data[i] = 8'(8'hA0 + i);

        tbl[4].len = 3; tbl[4].ip = 32'hC0A80001; tbl[4].port = 16'd7;
        tbl[4].hdr_delay = 2; tbl[4].mode = 0; tbl[4].exp_len = 16'd11; tbl[4].exp_drop = 0;
        tbl[4].data[0] = 8'h11; tbl[4].data[1] = 8'h22; tbl[4].data[2] = 8'h33;

        tbl[5].len = 16; tbl[5].ip = 32'hFFFF0000; tbl[5].port = 16'hFFFF;
        tbl[5].hdr_delay = 0; tbl[5].mode = 0; tbl[5].exp_len = 16'd24; tbl[5].exp_drop = 0;
        for (int i = 0; i < 16; i++) tbl[5].data[i] = 8'(8'hF0 - i);

        // reset values
        repeat (3) step();
        check("rst_tready", 32'(in_ready), 32'd0);
        check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst_tvalid", 32'(out_valid), 32'd0);
        check("rst_tlast", 32'(out_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_len", 32'(udp_len), 32'd0);
        check("rst_ip", dest_ip, 32'd0);
        check("rst_port", 32'(dest_port), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_tready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            frame_q.delete();
            for (int i = 0; i < tbl[v].len; i++) frame_q.push_back(tbl[v].data[i]);
            run_frame(tbl[v].ip, tbl[v].port, tbl[v].hdr_delay, tbl[v].mode,
                      tbl[v].exp_len, tbl[v].exp_drop);
            step();
        end

        // reset during SEND after two of four bytes
        frame_q.delete();
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        ip_adr = 32'h0B0B0B0B; port_nbr = 16'd42;
        send_frame();
        check("mid_hdr_valid", 32'(hdr_valid), 32'd1);
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        out_ready = 1'b1;
        check("mid_b0", 32'(out_data), 32'h01);
        step();
        check("mid_b1", 32'(out_data), 32'h02);
        step();
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_tvalid", 32'(out_valid), 32'd0);
        check("mid_rst_tlast", 32'(out_last), 32'd0);
        check("mid_rst_hdr", 32'(hdr_valid), 32'd0);
        check("mid_rst_len", 32'(udp_len), 32'd0);
        rst = 1'b0;
        step();
        check("mid_rst_tready", 32'(in_ready), 32'd1);
        frame_q.delete();
        frame_q.push_back(8'h5A);
        run_frame(32'h0C0C0C0C, 16'd99, 0, 0, 16'd9, 1'b0);
        step();

        // random frames, lengths straddling DEPTH
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, DEPTH + 4);
            frame_q.delete();
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            run_frame($urandom, 16'($urandom), $urandom_range(0, 3), 2,
                      model_len(len), model_drop(len));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
